two_tdm_demux_1_to_4: RTL and testbench
=======================================

Name: two_tdm_demux_1_to_4

Overview:
Receive end of the dual 4-to-1 mux link. The transmitting dual mux serialises two groups of four channel bits, one slot per clock-enable, using select A1:A0. This block:
- generates the matching slot index and drives it back to the mux select;
- de-serialises the two streams D1 and D2 into parallel words Y1 and Y2;
- frames on a sync pulse and flags framing errors.

Parameters:
- SLOT_W, 2, slot index width; slots per frame = 2**SLOT_W; Y width = 2**SLOT_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  slot strobe; one slot advances per clk with ce=1.
- fs  in  1  frame sync; qualified by ce; marks slot 0.
- G1_n  in  1  group-1 strobe, active-low; 1 blocks Y1 update.
- G2_n  in  1  group-2 strobe, active-low; 1 blocks Y2 update.
- D1  in  1  serial data, group 1.
- D2  in  1  serial data, group 2.
- A  out  SLOT_W  current slot index (drives upstream A1:A0).
- Y1  out  2**SLOT_W  group-1 parallel word; bit k = slot k.
- Y2  out  2**SLOT_W  group-2 parallel word.
- frame_vld  out  1  one-cycle pulse when Y1/Y2 commit.
- locked  out  1  1 while in LOCK.
- sync_err  out  1  framing error indication.

Behaviour:
- Reset (async assert, sync release): state=HUNT, A=0, shadow registers=0, Y1=Y2=0, frame_vld=0, locked=0, sync_err=0.
- All state changes happen only on clk with ce=1. ce=0 holds everything, except frame_vld and sync_err, which clear to 0 (pulses). fs with ce=0 is ignored.
- HUNT:
  - A held at 0.
  - ce&fs: sh1[0]<=D1, sh2[0]<=D2, A<=1, go LOCK, locked<=1.
  - ce&!fs: stay in HUNT.
- LOCK, ce=1, no fs:
  - sh1[A]<=D1, sh2[A]<=D2, A<=A+1, wrapping at 2**SLOT_W-1 -> 0.
- LOCK, ce=1, A==2**SLOT_W-1, no fs (last slot):
  - Y1<={D1,sh1[top-1:0]} if G1_n=0, else Y1 holds.
  - Y2 likewise under G2_n.
  - frame_vld<=1 regardless of strobes; A<=0.
  - Latency: slot-k bit visible on Y one clk after the last-slot ce.
- LOCK, ce&fs with A!=0 (early sync):
  - sync_err<=1 for one cycle; partial frame discarded, no commit.
  - Treat as a new slot 0: capture D into sh[0], A<=1, stay LOCK.
- LOCK, ce&fs with A==0: normal frame start.
- LOCK, ce&!fs with A==0 (missing sync):
  - sync_err<=1, go HUNT, locked<=0, A<=0; no capture.
- Boundary cases:
  - fs on the last slot is an early-sync error and takes priority over commit: no commit, no frame_vld.
  - With both G1_n=G2_n=1, frame_vld still pulses and Y holds.
  - Reset mid-frame discards the shadow; Y returns to 0.

Optional Feature:
- Macro: TDM_DEMUX_STICKY_ERR_EN.
- Defined:
  - sync_err is sticky: set by any framing error, held until reset or err_clr=1.
  - An extra input port err_clr (1 bit, sync) exists; err_clr has priority over a simultaneous new error (clear wins).
- Undefined: sync_err is the one-cycle pulse above; no err_clr port.

Decomposition:
- Package tdm_pkg:
  - state encoding HUNT=1'b0, LOCK=1'b1;
  - default SLOT_W=2;
  - localparam LAST_SLOT = 2**SLOT_W-1.
- One sub-module, tdm_slot_counter: SLOT_W-bit counter with ce, load-to-1, clear, and an is_last flag. Instantiated once; shared by both groups.

Test Plan:
- Reset then idle with ce=1, fs=0 for 8 clk -> locked=0, A=0, Y1=Y2=0, no frame_vld.
- Lock on first frame, G1_n=G2_n=0:
  - fs at slot 0; D1 bits 1,0,1,1 and D2 bits 0,1,1,0 over slots 0..3.
  - Expect: one clk after slot 3, Y1=4'b1101, Y2=4'b0110, frame_vld=1 for 1 clk, locked=1.
- Strobe gating: G1_n=1, G2_n=0 during the last-slot ce, D1=1111, D2=1010 -> Y1 holds previous value, Y2=4'b0101, frame_vld=1.
- ce throttling: insert ce=0 gaps of 3 clk between slots -> same Y values as the gap-free run; A holds during gaps.
- Early fs at slot 2:
  - Expect: sync_err pulse, no frame_vld, A=1 after that ce.
  - The following full frame commits correctly.
- Missing fs at slot 0 while locked -> sync_err pulse, locked=0, A=0, HUNT. Reset asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the dual TDM 1-to-4 demultiplexer.
// Optional build macro: TDM_DEMUX_STICKY_ERR_EN (sticky sync_err with err_clr).
package tdm_pkg;

    localparam int SLOT_W_DEF = 2;
    localparam int LAST_SLOT  = 2**SLOT_W_DEF - 1;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    // Index of the final slot for an arbitrary slot width.
    function automatic int last_slot(input int slot_w);
        return (2**slot_w) - 1;
    endfunction

endpackage

// File: rtl/two_tdm_demux_1_to_4_if.sv
// Link-side signal bundle between the upstream dual mux and the demux.
// Optional build macro: TDM_DEMUX_STICKY_ERR_EN adds the err_clr input.
interface two_tdm_demux_1_to_4_if
    import tdm_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF
) ();

    localparam int NW = 2**SLOT_W;

    logic              ce;
    logic              fs;
    logic              G1_n;
    logic              G2_n;
    logic              D1;
    logic              D2;
    logic [SLOT_W-1:0] A;
    logic [NW-1:0]     Y1;
    logic [NW-1:0]     Y2;
    logic              frame_vld;
    logic              locked;
    logic              sync_err;
`ifdef TDM_DEMUX_STICKY_ERR_EN
    logic              err_clr;

    modport master (
        output ce, fs, G1_n, G2_n, D1, D2, err_clr,
        input  A, Y1, Y2, frame_vld, locked, sync_err
    );

    modport slave (
        input  ce, fs, G1_n, G2_n, D1, D2, err_clr,
        output A, Y1, Y2, frame_vld, locked, sync_err
    );
`else
    modport master (
        output ce, fs, G1_n, G2_n, D1, D2,
        input  A, Y1, Y2, frame_vld, locked, sync_err
    );

    modport slave (
        input  ce, fs, G1_n, G2_n, D1, D2,
        output A, Y1, Y2, frame_vld, locked, sync_err
    );
`endif

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter shared by both groups: clear, load-to-1, advance, last-slot flag.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce_i,
    input  logic              load1_i,
    input  logic              clr_i,
    output logic [SLOT_W-1:0] cnt_o,
    output logic              is_last_o
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    // Clear outranks load, load outranks advance; advance wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = SLOT_W'(1);
        end else if (ce_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == SLOT_W'(last_slot(SLOT_W)));

endmodule

// File: rtl/two_tdm_demux_1_to_4.sv
// Receive end of the dual 4-to-1 TDM link: slot generation, framing, de-serialisation.
// Optional build macro: TDM_DEMUX_STICKY_ERR_EN (sticky sync_err, cleared by err_clr).
module two_tdm_demux_1_to_4
    import tdm_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    two_tdm_demux_1_to_4_if.slave         bus
);

    localparam int NW  = 2**SLOT_W;
    localparam int SHW = NW - 1;

    tdm_state_e        state_q, state_d;
    logic [SHW-1:0]    sh1_q, sh1_d;
    logic [SHW-1:0]    sh2_q, sh2_d;
    logic [NW-1:0]     y1_q, y1_d;
    logic [NW-1:0]     y2_q, y2_d;
    logic              frame_vld_q, frame_vld_d;
    logic              sync_err_q, sync_err_d;
    logic              err_evt;

    logic              cnt_ce;
    logic              cnt_load1;
    logic              cnt_clr;
    logic [SLOT_W-1:0] slot;
    logic              is_last;
    logic              at_zero;

    tdm_slot_counter #(
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_i      (cnt_ce),
        .load1_i   (cnt_load1),
        .clr_i     (cnt_clr),
        .cnt_o     (slot),
        .is_last_o (is_last)
    );

    assign at_zero = (slot == '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        frame_vld_d = 1'b0;
        err_evt     = 1'b0;
        cnt_ce      = 1'b0;
        cnt_load1   = 1'b0;
        cnt_clr     = 1'b0;

        if (bus.ce) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.fs) begin
                        sh1_d[0]  = bus.D1;
                        sh2_d[0]  = bus.D2;
                        cnt_load1 = 1'b1;
                        state_d   = LOCK;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end

                LOCK: begin
                    if (bus.fs) begin
                        // fs anywhere but slot 0 restarts the frame; fs on the last slot beats commit.
                        err_evt   = !at_zero;
                        sh1_d[0]  = bus.D1;
                        sh2_d[0]  = bus.D2;
                        cnt_load1 = 1'b1;
                    end else if (at_zero) begin
                        err_evt = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = HUNT;
                    end else if (is_last) begin
                        if (!bus.G1_n) y1_d = {bus.D1, sh1_q};
                        if (!bus.G2_n) y2_d = {bus.D2, sh2_q};
                        frame_vld_d = 1'b1;
                        cnt_clr     = 1'b1;
                    end else begin
                        for (int k = 0; k < SHW; k++) begin
                            if (slot == SLOT_W'(k)) begin
                                sh1_d[k] = bus.D1;
                                sh2_d[k] = bus.D2;
                            end
                        end
                        cnt_ce = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_STICKY_ERR_EN
    // Clear wins over an error detected in the same cycle.
    always_comb begin
        sync_err_d = sync_err_q;
        if (bus.err_clr) begin
            sync_err_d = 1'b0;
        end else if (err_evt) begin
            sync_err_d = 1'b1;
        end
    end
`else
    assign sync_err_d = err_evt;
`endif

    // NOTE: the shadow words are reset too, so a reset mid-frame cannot leak stale slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sh1_q       <= '0;
            sh2_q       <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            frame_vld_q <= frame_vld_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.A         = slot;
    assign bus.Y1        = y1_q;
    assign bus.Y2        = y2_q;
    assign bus.frame_vld = frame_vld_q;
    assign bus.locked    = (state_q == LOCK);
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_two_tdm_demux_1_to_4.sv
// Scoreboard bench for two_tdm_demux_1_to_4: directed framing cases plus random traffic
// checked against a slot-list reference model.
module tb_two_tdm_demux_1_to_4;
    import tdm_pkg::*;

    localparam int SW = SLOT_W_DEF;
    localparam int NS = 2**SW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    two_tdm_demux_1_to_4_if #(.SLOT_W(SW)) bus ();

    two_tdm_demux_1_to_4 #(.SLOT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [SW-1:0] a;
        logic          locked;
        logic [NS-1:0] y1;
        logic [NS-1:0] y2;
        logic          fv;
        logic          err;
    } exp_t;

    typedef struct {
        logic [NS-1:0] y1;
        logic [NS-1:0] y2;
    } frm_t;

    exp_t exp_q[$];
    frm_t frm_q[$];
    int   n_vec    = 0;
    int   n_miscmp = 0;

    // Reference model: framed yes/no, position in frame, bits collected so far.
    bit            m_locked;
    int            m_pos;
    bit            m_b1[$];
    bit            m_b2[$];
    logic [NS-1:0] m_y1;
    logic [NS-1:0] m_y2;
    bit            m_sticky;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_b1     = {};
        m_b2     = {};
        m_y1     = '0;
        m_y2     = '0;
        m_sticky = 1'b0;
    endtask

    // Drive one clock's inputs and queue the state expected right after that edge.
    task automatic step(input bit ce, input bit fs, input bit g1n, input bit g2n,
                        input bit d1, input bit d2);
        exp_t          e;
        frm_t          f;
        bit            fv;
        bit            err;
        logic [NS-1:0] w1;
        logic [NS-1:0] w2;
        @(negedge clk);
        bus.ce   = ce;
        bus.fs   = fs;
        bus.G1_n = g1n;
        bus.G2_n = g2n;
        bus.D1   = d1;
        bus.D2   = d2;
        fv  = 1'b0;
        err = 1'b0;
        if (ce) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    m_b1 = {d1};
                    m_b2 = {d2};
                    m_pos = 1;
                end
            end else if (fs) begin
                err  = (m_pos != 0);
                m_b1 = {d1};
                m_b2 = {d2};
                m_pos = 1;
            end else if (m_pos == 0) begin
                err = 1'b1;
                m_locked = 1'b0;
            end else if (m_pos == NS - 1) begin
                for (int k = 0; k < NS - 1; k++) begin
                    w1[k] = m_b1[k];
                    w2[k] = m_b2[k];
                end
                w1[NS-1] = d1;
                w2[NS-1] = d2;
                if (!g1n) m_y1 = w1;
                if (!g2n) m_y2 = w2;
                fv    = 1'b1;
                m_pos = 0;
                f.y1 = m_y1;
                f.y2 = m_y2;
                frm_q.push_back(f);
            end else begin
                m_b1.push_back(d1);
                m_b2.push_back(d2);
                m_pos++;
            end
        end
        e.a      = m_locked ? SW'(m_pos) : '0;
        e.locked = m_locked;
        e.y1     = m_y1;
        e.y2     = m_y2;
        e.fv     = fv;
`ifdef TDM_DEMUX_STICKY_ERR_EN
        if (err) m_sticky = 1'b1;
        e.err    = m_sticky;
`else
        e.err    = err;
`endif
        exp_q.push_back(e);
    endtask

    // One frame of slots 0..NS-1, bit k of d1/d2 sent in slot k, with ce=0 gaps before each slot.
    task automatic send_frame(input logic [NS-1:0] d1, input logic [NS-1:0] d2,
                              input bit g1n, input bit g2n, input int gap);
        for (int k = 0; k < NS; k++) begin
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom), g1n, g2n, 1'($urandom), 1'($urandom));
            end
            step(1'b1, (k == 0), g1n, g2n, d1[k], d2[k]);
        end
    endtask

    // Wait until the last driven vector has been clocked in.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_A",         32'(bus.A),         32'd0);
        check("rst_Y1",        32'(bus.Y1),        32'd0);
        check("rst_Y2",        32'(bus.Y2),        32'd0);
        check("rst_frame_vld", 32'(bus.frame_vld), 32'd0);
        check("rst_locked",    32'(bus.locked),    32'd0);
        check("rst_sync_err",  32'(bus.sync_err),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle status comparison plus frame commits popped on frame_vld.
    initial begin
        exp_t e;
        frm_t f;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("A",         32'(bus.A),         32'(e.a));
                check("locked",    32'(bus.locked),    32'(e.locked));
                check("Y1",        32'(bus.Y1),        32'(e.y1));
                check("Y2",        32'(bus.Y2),        32'(e.y2));
                check("frame_vld", 32'(bus.frame_vld), 32'(e.fv));
                check("sync_err",  32'(bus.sync_err),  32'(e.err));
            end
            if (bus.frame_vld === 1'b1) begin
                if (frm_q.size() == 0) begin
                    n_vec++;
                    n_miscmp++;
                    $display("FAIL frame_commit: got frame_vld=1, expected no commit (t=%0t)", $time);
                end else begin
                    f = frm_q.pop_front();
                    check("frame_Y1", 32'(bus.Y1), 32'(f.y1));
                    check("frame_Y2", 32'(bus.Y2), 32'(f.y2));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.ce   = 1'b0;
        bus.fs   = 1'b0;
        bus.G1_n = 1'b1;
        bus.G2_n = 1'b1;
        bus.D1   = 1'b0;
        bus.D2   = 1'b0;
`ifdef TDM_DEMUX_STICKY_ERR_EN
        bus.err_clr = 1'b0;
`endif
        model_reset();
        do_reset();

        // Idle with ce=1, no sync: stays hunting.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        settle();
        check("idle_locked", 32'(bus.locked), 32'd0);
        check("idle_A",      32'(bus.A),      32'd0);
        check("idle_Y1",     32'(bus.Y1),     32'd0);

        // First frame: D1 slots 1,0,1,1 and D2 slots 0,1,1,0.
        send_frame(4'b1101, 4'b0110, 1'b0, 1'b0, 0);
        settle();
        check("first_Y1",        32'(bus.Y1),        32'h0000_000d);
        check("first_Y2",        32'(bus.Y2),        32'h0000_0006);
        check("first_frame_vld", 32'(bus.frame_vld), 32'd1);
        check("first_locked",    32'(bus.locked),    32'd1);

        // Group-1 strobe blocked: Y1 holds, Y2 updates.
        send_frame(4'b1111, 4'b0101, 1'b1, 1'b0, 0);
        settle();
        check("gate_Y1",        32'(bus.Y1),        32'h0000_000d);
        check("gate_Y2",        32'(bus.Y2),        32'h0000_0005);
        check("gate_frame_vld", 32'(bus.frame_vld), 32'd1);

        // Both strobes blocked: pulse without update.
        send_frame(4'b0000, 4'b1111, 1'b1, 1'b1, 0);
        settle();
        check("nogate_Y2",        32'(bus.Y2),        32'h0000_0005);
        check("nogate_frame_vld", 32'(bus.frame_vld), 32'd1);

        // ce throttling with 3-clock gaps.
        send_frame(4'b1101, 4'b0110, 1'b0, 1'b0, 3);
        settle();
        check("gap_Y1", 32'(bus.Y1), 32'h0000_000d);
        check("gap_Y2", 32'(bus.Y2), 32'h0000_0006);

        // Early fs at slot 2.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("early_sync_err",  32'(bus.sync_err),  32'd1);
        check("early_frame_vld", 32'(bus.frame_vld), 32'd0);
        check("early_A",         32'(bus.A),         32'd1);
        for (int k = 1; k < NS; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        send_frame(4'b0011, 4'b1100, 1'b0, 1'b0, 0);
        settle();
        check("after_early_Y1", 32'(bus.Y1), 32'h0000_0003);
        check("after_early_Y2", 32'(bus.Y2), 32'h0000_000c);

        // fs on the last slot: error, no commit.
        for (int k = 0; k < NS - 1; k++) step(1'b1, (k == 0), 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("lastfs_frame_vld", 32'(bus.frame_vld), 32'd0);
        check("lastfs_Y1",        32'(bus.Y1),        32'h0000_0003);
        for (int k = 1; k < NS; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));

        // Missing fs at slot 0 while locked.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("miss_sync_err", 32'(bus.sync_err), 32'd1);
        check("miss_locked",   32'(bus.locked),   32'd0);
        check("miss_A",        32'(bus.A),        32'd0);

        // Reset in the middle of a frame.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();

        // Random traffic, mostly well framed with occasional misplaced or missing syncs.
        for (int i = 0; i < 800; i++) begin
            bit ce;
            bit fs;
            ce = ($urandom_range(3) != 0);
            if (!m_locked || m_pos == 0) fs = ($urandom_range(15) != 0);
            else                         fs = ($urandom_range(23) == 0);
            step(ce, fs, ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 1'($urandom), 1'($urandom));
        end

        settle();
        settle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("frm_q_drained", 32'(frm_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
